// File: rtl/cpu_pkg.sv
// Shared constants for the execute stage: operand width, opcodes, ALU control
// states and the bit positions of the status flags.
package cpu_pkg;

  localparam int WIDTH = 16;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd5;
  localparam logic [3:0] OP_PASSB = 4'd6;
  localparam logic [3:0] OP_SHL   = 4'd7;
  localparam logic [3:0] OP_SHR   = 4'd8;
  localparam logic [3:0] OP_MUL   = 4'd9;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } alu_state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one partial-product step per clock.
// prod/fin are combinational so the owner can register the final product on the last step.
module alu_mul_seq import cpu_pkg::*; #(
  parameter int WIDTH = cpu_pkg::WIDTH,
  parameter int ITERS = WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 go,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 fin,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int CW = $clog2(ITERS);

  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     sum;
  logic [CW-1:0]      cnt;

  // Upper half accumulates the multiplicand; the multiplier drains out of the lower half.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    acc_nxt = {sum, acc[WIDTH-1:1]};
  end

  assign fin  = busy && (cnt == CW'(ITERS-1));
  assign prod = acc_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q  <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (go && !busy) begin
      a_q  <= a;
      acc  <= {{WIDTH{1'b0}}, b};
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (fin) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute stage: single-cycle ALU ops plus a sequential MUL, with registered
// result/flags and a done pulse in the cycle they update.
module alu_exec import cpu_pkg::*; #(
  parameter int WIDTH     = cpu_pkg::WIDTH,
  parameter int MUL_ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             busy,
  output logic             done,
  output logic             err
);

  alu_state_t state, state_nxt;

  logic               mul_go, mul_busy, mul_fin;
  logic [2*WIDTH-1:0] mul_prod;
  logic               alu_wr, alu_c, alu_v, alu_ill;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH:0]     sum_ext, dif_ext;
  logic [3:0]         flags_q;

  function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = (r == '0);
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  alu_mul_seq #(.WIDTH(WIDTH), .ITERS(MUL_ITERS)) u_mul (
    .clk  (clk),
    .rst_n(rst_n),
    .go   (mul_go),
    .a    (dataA),
    .b    (dataB),
    .busy (mul_busy),
    .fin  (mul_fin),
    .prod (mul_prod)
  );

  always_comb begin
    sum_ext = {1'b0, dataA} + {1'b0, dataB};
    dif_ext = {1'b0, dataA} - {1'b0, dataB};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (dataA[WIDTH-1] == dataB[WIDTH-1]) && (sum_ext[WIDTH-1] != dataA[WIDTH-1]);
      end
      OP_SUB: begin
        // Carry is "no borrow": set when A >= B unsigned.
        alu_res = dif_ext[WIDTH-1:0];
        alu_c   = ~dif_ext[WIDTH];
        alu_v   = (dataA[WIDTH-1] != dataB[WIDTH-1]) && (dif_ext[WIDTH-1] != dataA[WIDTH-1]);
      end
      OP_AND:   alu_res = dataA & dataB;
      OP_OR:    alu_res = dataA | dataB;
      OP_XOR:   alu_res = dataA ^ dataB;
      OP_NOT:   alu_res = ~dataA;
      OP_PASSB: alu_res = dataB;
      OP_SHL: begin
        alu_res = {dataA[WIDTH-2:0], 1'b0};
        alu_c   = dataA[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, dataA[WIDTH-1:1]};
        alu_c   = dataA[0];
      end
      OP_MUL:  alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    mul_go    = 1'b0;
    alu_wr    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mul_go    = 1'b1;
            state_nxt = S_MUL;
          end else begin
            alu_wr = 1'b1;
          end
        end
      end
      S_MUL:   if (mul_fin) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Illegal opcodes fall through the ALU as result 0, so Z comes out set naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result  <= '0;
      flags_q <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= alu_wr | mul_fin;
      err  <= alu_wr & alu_ill;
      if (alu_wr) begin
        result  <= alu_res;
        flags_q <= pack_flags(alu_res, alu_c, alu_v);
      end else if (mul_fin) begin
        result  <= mul_prod[WIDTH-1:0];
        flags_q <= pack_flags(mul_prod[WIDTH-1:0], |mul_prod[2*WIDTH-1:WIDTH], 1'b0);
      end
    end
  end

  assign busy   = mul_busy;
  assign flag_z = flags_q[FLAG_Z];
  assign flag_n = flags_q[FLAG_N];
  assign flag_c = flags_q[FLAG_C];
  assign flag_v = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed vector table, MUL timing/abort sequences and
// randomized ops checked against an arithmetic reference model.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [15:0] dataA, dataB;
  logic [15:0] result;
  logic        flag_z, flag_n, flag_c, flag_v, busy, done, err;

  int n_chk  = 0;
  int n_fail = 0;

  alu_exec dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .dataA (dataA),
    .dataB (dataB),
    .result(result),
    .flag_z(flag_z),
    .flag_n(flag_n),
    .flag_c(flag_c),
    .flag_v(flag_v),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [3:0]  f;   // {Z,N,C,V}
    logic        e;
  } vec_t;

  vec_t tbl [15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] flags_now();
    return {flag_z, flag_n, flag_c, flag_v};
  endfunction

  // Reference: plain integer arithmetic on the documented operation rules.
  function automatic void model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic [3:0] f, output logic e);
    longint ua, ub, full;
    int sa, sb, sr;
    logic c, v;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    c = 1'b0; v = 1'b0; e = 1'b0; full = 0;
    case (o)
      4'd0: begin full = ua + ub; sr = sa + sb; c = full > 65535; v = (sr > 32767) || (sr < -32768); end
      4'd1: begin full = ua - ub; sr = sa - sb; c = ua >= ub;     v = (sr > 32767) || (sr < -32768); end
      4'd2: full = longint'(a & b);
      4'd3: full = longint'(a | b);
      4'd4: full = longint'(a ^ b);
      4'd5: full = 65535 - ua;
      4'd6: full = ub;
      4'd7: begin full = ua * 2; c = full > 65535; end
      4'd8: begin full = ua / 2; c = (ua % 2) == 1; end
      4'd9: begin full = ua * ub; c = full > 65535; end
      default: e = 1'b1;
    endcase
    r = full[15:0];
    f = {r == 16'd0, r[15], c, v};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  // Issue one op and wait (bounded) for its done pulse; operands are scrambled after issue.
  task automatic run_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b, input string nm);
    logic [15:0] er;
    logic [3:0]  ef;
    logic        ee;
    int          lat;
    model(o, a, b, er, ef, ee);
    start = 1'b1; op = o; dataA = a; dataB = b;
    step();
    start = 1'b0; op = 4'($urandom); dataA = 16'($urandom); dataB = 16'($urandom);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    check({nm, "_latency"}, lat, (o == 4'd9) ? 17 : 1);
    check({nm, "_result"}, result, er);
    check({nm, "_flags"}, flags_now(), ef);
    check({nm, "_err"}, err, ee);
  endtask

  // MUL with cycle-accurate busy/done checks; optional start poke while busy.
  task automatic mul_window(input logic [15:0] a, input logic [15:0] b, input int poke,
                            input logic [15:0] er, input logic [3:0] ef, input string nm);
    int bad = 0;
    start = 1'b1; op = 4'd9; dataA = a; dataB = b;
    step();
    start = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      op = 4'($urandom); dataA = 16'($urandom); dataB = 16'($urandom);
      if (i == poke) begin start = 1'b1; op = 4'd0; end
      step();
      start = 1'b0;
    end
    check({nm, "_busy_window"}, bad, 0);
    check({nm, "_busy_done_err"}, {busy, done, err}, 3'b010);
    check({nm, "_result"}, result, er);
    check({nm, "_flags"}, flags_now(), ef);
    step();
    check({nm, "_no_extra_done"}, done, 1'b0);
  endtask

  initial begin
    logic        seen;
    logic [3:0]  o;

    tbl[0]  = '{4'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1'b0};
    tbl[1]  = '{4'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1'b0};
    tbl[2]  = '{4'd1, 16'h0003, 16'h0005, 16'hFFFE, 4'b0100, 1'b0};
    tbl[3]  = '{4'd1, 16'h0005, 16'h0005, 16'h0000, 4'b1010, 1'b0};
    tbl[4]  = '{4'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 1'b0};
    tbl[5]  = '{4'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1'b0};
    tbl[6]  = '{4'd3, 16'hF000, 16'h000F, 16'hF00F, 4'b0100, 1'b0};
    tbl[7]  = '{4'd4, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b1000, 1'b0};
    tbl[8]  = '{4'd5, 16'h0000, 16'h1234, 16'hFFFF, 4'b0100, 1'b0};
    tbl[9]  = '{4'd6, 16'hFFFF, 16'h1234, 16'h1234, 4'b0000, 1'b0};
    tbl[10] = '{4'd7, 16'h8001, 16'h0000, 16'h0002, 4'b0010, 1'b0};
    tbl[11] = '{4'd8, 16'h0003, 16'h0000, 16'h0001, 4'b0010, 1'b0};
    tbl[12] = '{4'd8, 16'h0001, 16'hFFFF, 16'h0000, 4'b1010, 1'b0};
    tbl[13] = '{4'd12, 16'h1234, 16'h5678, 16'h0000, 4'b1000, 1'b1};
    tbl[14] = '{4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000, 1'b1};

    rst_n = 1'b0; start = 1'b0; op = 4'd0; dataA = '0; dataB = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    check("reset_result", result, 16'h0000);
    check("reset_flags", flags_now(), 4'b0000);
    check("reset_busy_done_err", {busy, done, err}, 3'b000);

    // Back-to-back: start stays high across consecutive table entries.
    for (int i = 0; i < 15; i++) begin
      start = 1'b1; op = tbl[i].op; dataA = tbl[i].a; dataB = tbl[i].b;
      step();
      check($sformatf("vec%0d_done", i), done, 1'b1);
      check($sformatf("vec%0d_err", i), err, tbl[i].e);
      check($sformatf("vec%0d_result", i), result, tbl[i].r);
      check($sformatf("vec%0d_flags", i), flags_now(), tbl[i].f);
    end
    start = 1'b0;
    step();
    check("idle_hold_done", {done, err}, 2'b00);
    check("idle_hold_result", result, 16'h0000);

    mul_window(16'h0123, 16'h0045, 0, 16'h4E6F, 4'b0000, "mul_basic");
    mul_window(16'hFFFF, 16'h0002, 0, 16'hFFFE, 4'b0110, "mul_carry");
    mul_window(16'h0123, 16'h0045, 5, 16'h4E6F, 4'b0000, "mul_start_ignored");

    // Reset mid-MUL: abort, no done, then an illegal op.
    run_op(4'd0, 16'h7FFF, 16'h0001, "pre_abort_add");
    start = 1'b1; op = 4'd9; dataA = 16'h1234; dataB = 16'h5678;
    step();
    start = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    step();
    check("abort_busy_done", {busy, done}, 2'b00);
    check("abort_result", result, 16'h0000);
    check("abort_flags", flags_now(), 4'b0000);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    check("abort_no_late_done", seen, 1'b0);
    run_op(4'd12, 16'hABCD, 16'h1357, "post_abort_illegal");

    for (int k = 0; k < 150; k++) begin
      o = 4'($urandom_range(0, 15));
      run_op(o, pick(), pick(), $sformatf("rnd%0d_op%0d", k, o));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
